instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Initiator side of the instruction-memory interface: owns the PC, drives the word address
//   into the combinational instruction memory and registers the returned word into the IF/ID
//   pipeline register. Handles stall, branch/jump redirect and the post-reset boot cycle.
//   Sits between the hazard/branch logic (ID stage) and the instruction memory.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   CNT_W     16             width of the fetched-instruction counter
// PORTS
//   Clk            in   1      clock; all state updates on rising edge
//   Reset          in   1      synchronous, active-high reset
//   Stall          in   1      hold PC and IF/ID contents this cycle
//   BranchTaken    in   1      redirect PC to BranchTarget
//   BranchTarget   in   32     branch destination (byte address)
//   Jump           in   1      redirect PC to JumpTarget
//   JumpTarget     in   32     jump destination (byte address)
//   Address        out  32     to instruction memory; equals PC register
//   Instruction    in   32     from instruction memory, valid same cycle as Address
//   IF_Instruction out  32     registered instruction to ID
//   IF_PCPlus4     out  32     registered PC+4 of IF_Instruction
//   IF_Valid       out  1      IF_Instruction is a real fetch (0 = bubble)
//   FetchCount     out  CNT_W  count of instructions accepted into IF/ID
// BEHAVIOUR
//   Reset (sync, any state, mid-operation included): PC=RESET_PC, IF_Instruction=32'h0,
//     IF_PCPlus4=32'h0, IF_Valid=0, FetchCount=0, state=BOOT.
//   Address = PC (combinational from register); imem latency is zero.
//   States: BOOT -> RUN unconditionally after 1 cycle; BOOT does not capture or advance PC.
//     RUN -> BUBBLE on redirect (only when delay slot disabled); BUBBLE -> RUN next cycle.
//   Priority per cycle in RUN/BUBBLE: Reset > Jump > BranchTaken > Stall > sequential.
//   Sequential: PC<=PC+4; IF_Instruction<=Instruction; IF_PCPlus4<=PC+4; IF_Valid<=1;
//     FetchCount<=FetchCount+1.
//   Stall (no redirect): PC, IF/ID regs and FetchCount hold; state holds.
//   Redirect (Jump or BranchTaken) overrides Stall: PC<=target with bits[1:0] forced to 0.
//     Jump and BranchTaken together: Jump target used.
//   Redirect in BUBBLE is honoured identically (new target, stays BUBBLE one more cycle).
//   Arithmetic: PC+4 is 32-bit modulo 2^32 (32'hFFFF_FFFC wraps to 0); no range check
//     against imem depth. FetchCount wraps at 2^CNT_W.
//   BUBBLE cycle: IF/ID captures normally from the new PC (bubble is the cycle of redirect).
// CONFIGURATION
//   BRANCH_DELAY_SLOT_EN defined: on redirect the current Instruction is captured into IF/ID
//     as the delay-slot instruction (IF_Valid=1, FetchCount++); RUN stays RUN; no BUBBLE.
//   Not defined: on redirect IF_Instruction<=32'h0, IF_Valid<=0, IF_PCPlus4<=32'h0,
//     FetchCount holds; state -> BUBBLE.
// STRUCTURE
//   Package fetch_pkg: RESET_PC default, NOP_WORD=32'h0, PC_INC=4, state encoding
//     (BOOT=2'd0, RUN=2'd1, BUBBLE=2'd2).
//   Sub-module fetch_pc_reg: PC register with next-PC mux (reset/jump/branch/stall/+4).
//   Top holds FSM, IF/ID register and FetchCount.
// TESTING
//   Reset 3 cycles, release, imem word i = i*3 -> cycle1 IF_Valid=0 (BOOT); cycle2
//     IF_Instruction=0, IF_PCPlus4=4; cycle3 IF_Instruction=3, IF_PCPlus4=8.
//   Stall high 2 cycles at PC=0x10 -> Address stays 0x10, IF/ID and FetchCount unchanged.
//   BranchTaken=1, BranchTarget=0x43 at PC=0x20 -> next Address=0x40; no-macro build:
//     IF_Valid=0 one cycle then IF_Instruction=mem[16]; macro build: IF_Instruction=mem[8].
//   Jump=1 (0x100) and BranchTaken=1 (0x80) with Stall=1 -> next Address=0x100.
//   Force PC=32'hFFFF_FFFC, run 1 cycle -> Address=0, IF_PCPlus4=0.
//   Assert Reset mid-run after 10 fetches -> next cycle PC=RESET_PC, FetchCount=0, IF_Valid=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Package fetch_pkg: shared constants and state encoding for the instruction
// fetch unit.
//   RESET_PC_DEFAULT : default PC after reset
//   NOP_WORD         : word loaded into IF/ID on a bubble
//   PC_INC           : sequential PC increment (one 32-bit word)
//   fetch_state_e    : BOOT / RUN / BUBBLE encoding
//   word_align()     : clears byte-offset bits of a target address
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_e;

  // Redirect targets are byte addresses; the PC only ever holds word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Interface instruction_fetch_unit_if: groups the fetch unit's control inputs
// from the ID stage, the instruction-memory port and the IF/ID outputs.
//   master : the fetch unit (drives Address and the IF/ID outputs)
//   slave  : the environment (hazard/branch logic + instruction memory)
// Parameter CNT_W sets the width of FetchCount.
interface instruction_fetch_unit_if #(
  parameter int CNT_W = 16
);
  logic              Stall;
  logic              BranchTaken;
  logic [31:0]       BranchTarget;
  logic              Jump;
  logic [31:0]       JumpTarget;
  logic [31:0]       Address;
  logic [31:0]       Instruction;
  logic [31:0]       IF_Instruction;
  logic [31:0]       IF_PCPlus4;
  logic              IF_Valid;
  logic [CNT_W-1:0]  FetchCount;

  modport master (
    input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
    output Address, IF_Instruction, IF_PCPlus4, IF_Valid, FetchCount
  );

  modport slave (
    output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
    input  Address, IF_Instruction, IF_PCPlus4, IF_Valid, FetchCount
  );
endinterface

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Module fetch_pc_reg: program counter with its next-PC selection.
// Ports:
//   clk, srst      : clock, synchronous active-high reset (loads RESET_PC)
//   en             : PC may change this cycle (low during the boot cycle)
//   stall          : hold PC unless a redirect is present
//   jump/jump_target, branch/branch_target : redirect requests (byte addresses)
//   pc             : current PC (word aligned)
// Priority: reset > jump > branch > stall > PC+4 (modulo 2^32).
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        en,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    if (en) begin
      if (jump)
        pc_next = word_align(jump_target);
      else if (branch)
        pc_next = word_align(branch_target);
      else if (!stall)
        pc_next = pc_reg + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      pc_reg <= RESET_PC;
    else
      pc_reg <= pc_next;
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Module instruction_fetch_unit: initiator side of the instruction-memory
// port. Owns the PC (via fetch_pc_reg), presents it as the memory address and
// registers the returned word into the IF/ID pipeline register.
// Ports:
//   Clk   : clock, all state on rising edge
//   Reset : synchronous active-high reset
//   bus   : instruction_fetch_unit_if.master (stall/redirect inputs, imem
//           port, IF_Instruction / IF_PCPlus4 / IF_Valid / FetchCount)
// Build option: define BRANCH_DELAY_SLOT_EN to capture the instruction in the
// redirect cycle as a delay slot instead of inserting a bubble.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  instruction_fetch_unit_if.master bus
);

  fetch_state_e     state_reg;
  logic [31:0]      if_instr_reg;
  logic [31:0]      if_pc4_reg;
  logic             if_valid_reg;
  logic [CNT_W-1:0] fetch_cnt_reg;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;

  assign redirect = bus.Jump | bus.BranchTaken;
  assign pc_plus4 = pc + PC_INC;

  // The PC is frozen during the boot cycle so the first fetched word is the
  // one at RESET_PC.
  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (Clk),
    .srst          (Reset),
    .en            (state_reg != BOOT),
    .stall         (bus.Stall),
    .jump          (bus.Jump),
    .jump_target   (bus.JumpTarget),
    .branch        (bus.BranchTaken),
    .branch_target (bus.BranchTarget),
    .pc            (pc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= BOOT;
      if_instr_reg  <= NOP_WORD;
      if_pc4_reg    <= 32'h0;
      if_valid_reg  <= 1'b0;
      fetch_cnt_reg <= '0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg <= RUN;
        end
        RUN, BUBBLE: begin
          if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
            // The word at the current PC executes as the delay slot.
            if_instr_reg  <= bus.Instruction;
            if_pc4_reg    <= pc_plus4;
            if_valid_reg  <= 1'b1;
            fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
            state_reg     <= RUN;
`else
            // Squash the wrong-path word; a redirect in BUBBLE re-enters BUBBLE.
            if_instr_reg  <= NOP_WORD;
            if_pc4_reg    <= 32'h0;
            if_valid_reg  <= 1'b0;
            state_reg     <= BUBBLE;
`endif
          end else if (!bus.Stall) begin
            if_instr_reg  <= bus.Instruction;
            if_pc4_reg    <= pc_plus4;
            if_valid_reg  <= 1'b1;
            fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
            state_reg     <= RUN;
          end
        end
        default: begin
          state_reg <= BOOT;
        end
      endcase
    end
  end

  assign bus.Address        = pc;
  assign bus.IF_Instruction = if_instr_reg;
  assign bus.IF_PCPlus4     = if_pc4_reg;
  assign bus.IF_Valid       = if_valid_reg;
  assign bus.FetchCount     = fetch_cnt_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. Directed per-cycle stimulus pushes the
// hand-computed expected outputs into a scoreboard queue; a monitor on the
// falling edge pops and compares once the DUT has taken that cycle's edge.
// Instruction memory model: word i holds i*3.
// Expectations follow BRANCH_DELAY_SLOT_EN when it is defined.
module tb_instruction_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  instruction_fetch_unit_if #(.CNT_W(16)) bus ();

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Zero-latency instruction memory.
  assign bus.Instruction = (bus.Address >> 2) * 32'd3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: compares the entry whose target cycle has just completed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc) begin
        failures = failures + 1;
        $display("FAIL %s: entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (bus.Address !== e.addr || bus.IF_Instruction !== e.instr ||
                   bus.IF_PCPlus4 !== e.pc4 || bus.IF_Valid !== e.valid ||
                   bus.FetchCount !== e.cnt) begin
        failures = failures + 1;
        $display("FAIL %s: got addr=%h instr=%h pc4=%h valid=%b cnt=%0d, want addr=%h instr=%h pc4=%h valid=%b cnt=%0d",
                 e.name, bus.Address, bus.IF_Instruction, bus.IF_PCPlus4, bus.IF_Valid,
                 bus.FetchCount, e.addr, e.instr, e.pc4, e.valid, e.cnt);
      end else begin
        $display("txn %-12s addr=%h instr=%h pc4=%h valid=%b cnt=%0d ok",
                 e.name, bus.Address, bus.IF_Instruction, bus.IF_PCPlus4, bus.IF_Valid,
                 bus.FetchCount);
      end
    end
  end

  // One cycle of stimulus plus the outputs expected after the next rising edge.
  task automatic step(input string nm, input logic r, input logic s,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic [31:0] ea, input logic [31:0] ei,
                      input logic [31:0] ep, input logic ev, input logic [15:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.Stall        = s;
    bus.BranchTaken  = b;
    bus.BranchTarget = bt;
    bus.Jump         = j;
    bus.JumpTarget   = jt;
    e.cyc   = cyc + 1;
    e.name  = nm;
    e.addr  = ea;
    e.instr = ei;
    e.pc4   = ep;
    e.valid = ev;
    e.cnt   = ec;
    exp_q.push_back(e);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    bus.Stall        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'h0;
    bus.Jump         = 1'b0;
    bus.JumpTarget   = 32'h0;

    // name         rst s  br  btgt          j   jtgt          addr          instr                       pc4                     v        cnt
    step("reset0",  1, 0, 0, 32'h0,  0, 32'h0, 32'h00, 32'h0, 32'h0, 0, 16'd0);
    step("reset1",  1, 0, 0, 32'h0,  0, 32'h0, 32'h00, 32'h0, 32'h0, 0, 16'd0);
    step("reset2",  1, 0, 0, 32'h0,  0, 32'h0, 32'h00, 32'h0, 32'h0, 0, 16'd0);
    step("boot",    0, 0, 0, 32'h0,  0, 32'h0, 32'h00, 32'h0, 32'h0, 0, 16'd0);
    step("fetch0",  0, 0, 0, 32'h0,  0, 32'h0, 32'h04, 32'd0, 32'h04, 1, 16'd1);
    step("fetch1",  0, 0, 0, 32'h0,  0, 32'h0, 32'h08, 32'd3, 32'h08, 1, 16'd2);
    step("fetch2",  0, 0, 0, 32'h0,  0, 32'h0, 32'h0C, 32'd6, 32'h0C, 1, 16'd3);
    step("fetch3",  0, 0, 0, 32'h0,  0, 32'h0, 32'h10, 32'd9, 32'h10, 1, 16'd4);
    step("stall0",  0, 1, 0, 32'h0,  0, 32'h0, 32'h10, 32'd9, 32'h10, 1, 16'd4);
    step("stall1",  0, 1, 0, 32'h0,  0, 32'h0, 32'h10, 32'd9, 32'h10, 1, 16'd4);
    step("fetch4",  0, 0, 0, 32'h0,  0, 32'h0, 32'h14, 32'd12, 32'h14, 1, 16'd5);
    step("fetch5",  0, 0, 0, 32'h0,  0, 32'h0, 32'h18, 32'd15, 32'h18, 1, 16'd6);
    step("fetch6",  0, 0, 0, 32'h0,  0, 32'h0, 32'h1C, 32'd18, 32'h1C, 1, 16'd7);
    step("fetch7",  0, 0, 0, 32'h0,  0, 32'h0, 32'h20, 32'd21, 32'h20, 1, 16'd8);
    // Branch to 0x43 from PC=0x20: target aligned to 0x40.
    step("branch",  0, 0, 1, 32'h43, 0, 32'h0, 32'h40,
         DS ? 32'd24 : 32'd0, DS ? 32'h24 : 32'h0, DS, DS ? 16'd9 : 16'd8);
    step("after_br", 0, 0, 0, 32'h0, 0, 32'h0, 32'h44, 32'd48, 32'h44, 1,
         DS ? 16'd10 : 16'd9);
    // Jump beats branch and stall.
    step("jmp_br_st", 0, 1, 1, 32'h80, 1, 32'h100, 32'h100,
         DS ? 32'd51 : 32'd0, DS ? 32'h48 : 32'h0, DS, DS ? 16'd11 : 16'd9);
    // Second redirect (in BUBBLE for the no-delay-slot build) to the top word.
    step("jmp_top", 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
         DS ? 32'd192 : 32'd0, DS ? 32'h104 : 32'h0, DS, DS ? 16'd12 : 16'd9);
    step("wrap",    0, 0, 0, 32'h0,  0, 32'h0, 32'h00, 32'hBFFF_FFFD, 32'h0, 1,
         DS ? 16'd13 : 16'd10);
    step("post_wrap0", 0, 0, 0, 32'h0, 0, 32'h0, 32'h04, 32'd0, 32'h04, 1,
         DS ? 16'd14 : 16'd11);
    step("post_wrap1", 0, 0, 0, 32'h0, 0, 32'h0, 32'h08, 32'd3, 32'h08, 1,
         DS ? 16'd15 : 16'd12);
    step("mid_reset", 1, 0, 0, 32'h0, 0, 32'h0, 32'h00, 32'h0, 32'h0, 0, 16'd0);
    step("reboot",  0, 0, 0, 32'h0,  0, 32'h0, 32'h00, 32'h0, 32'h0, 0, 16'd0);
    step("refetch", 0, 0, 0, 32'h0,  0, 32'h0, 32'h04, 32'd0, 32'h04, 1, 16'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL %s: never compared, expected at cycle %0d, now %0d", e.name, e.cyc, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
